// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a 2-entry skid buffer and zero-bubble flush.
// Define PIPE_STAGE_STATS_EN to add saturating stall_cnt/bubble_cnt outputs.
module pipe_stage_skid #(
  parameter int WIDTH = 32,
  parameter int LANES = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*LANES-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*LANES-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            bubble_cnt
`endif
);
  localparam int W = WIDTH * LANES;
  // Encoding is {main_v, skid_v}; 01 is unreachable
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, TWO = 2'b11} state_t;
  state_t state, state_nx;
  logic [W-1:0] main_q, main_nx, skid_q, skid_nx;
  logic accept, consume;
  assign in_ready  = !state[0];
  assign out_valid = state[1];
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nx;
      main_q <= main_nx;
      skid_q <= skid_nx;
    end
  end
  // main is zeroed whenever it empties so out_data is 0 without a mux on out_valid
  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    if (flush) begin
      state_nx = EMPTY;
      main_nx  = '0;
      skid_nx  = '0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          main_nx  = in_data;
          state_nx = ONE;
        end
        ONE: if (accept && consume) main_nx = in_data;
          else if (accept) begin
            skid_nx  = in_data;
            state_nx = TWO;
          end else if (consume) begin
            main_nx  = '0;
            state_nx = EMPTY;
          end
        TWO: if (consume) begin
          main_nx  = skid_q;
          skid_nx  = '0;
          state_nx = ONE;
        end
        default: begin
          state_nx = EMPTY;
          main_nx  = '0;
          skid_nx  = '0;
        end
      endcase
    end
  end
`ifdef PIPE_STAGE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (!out_valid && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: randomized self-checking bench for pipe_stage_skid against a 2-deep FIFO model.
module tb_pipe_stage_skid;
  localparam int WIDTH = 32;
  localparam int LANES = 7;
  localparam int W = WIDTH * LANES;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [W-1:0] in_data = '0, out_data;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif
  logic [W-1:0] q[$];
  int m_stall, m_bubble;
  int total = 0, bad = 0;
  pipe_stage_skid #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] d;
    for (int k = 0; k < LANES; k++) d[k*WIDTH +: WIDTH] = $urandom;
    return d;
  endfunction
  function automatic logic [W-1:0] lane0(input logic [WIDTH-1:0] v);
    logic [W-1:0] d;
    d = '0;
    d[WIDTH-1:0] = v;
    return d;
  endfunction
  function automatic logic [W-1:0] m_data();
    return q.size() > 0 ? q[0] : '0;
  endfunction
  // Advance one clock; the model is a plain 2-entry FIFO cleared by reset/flush
  task automatic step();
    bit acc, con;
    acc = in_valid && q.size() < 2;
    con = q.size() > 0 && out_ready;
    if (reset) begin
      m_stall = 0;
      m_bubble = 0;
    end else begin
      if (q.size() > 0 && !out_ready && m_stall != -1) m_stall++;
      if (q.size() == 0 && m_bubble != -1) m_bubble++;
    end
    @(posedge clk);
    #1;
    if (reset || flush) q.delete();
    else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
  endtask
  task automatic test_reset();
    reset = 1; flush = 0; in_valid = 1; in_data = rand_data(); out_ready = 0;
    step();
    reset = 0; in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid cyc%0d got=%b exp=0", i, out_valid); end
      total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data cyc%0d got=%h exp=0", i, out_data); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready cyc%0d got=%b exp=1", i, in_ready); end
    end
`ifdef PIPE_STAGE_STATS_EN
    total++; if (bubble_cnt !== 32'd3) begin bad++; $display("FAIL reset_bubble got=%0d exp=3", bubble_cnt); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
`endif
  endtask
  task automatic test_stream();
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_data = lane0(i);
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid %0d got=%b exp=1", i, out_valid); end
      total++; if (out_data !== lane0(i)) begin bad++; $display("FAIL stream_data %0d got=%h exp=%h", i, out_data, lane0(i)); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready %0d got=%b exp=1", i, in_ready); end
    end
    in_valid = 0;
    step();
    total++; if (out_valid !== 1'b0 || out_data !== '0) begin bad++; $display("FAIL stream_drain got=%b/%h exp=0/0", out_valid, out_data); end
  endtask
  task automatic test_backpressure();
    out_ready = 0; in_valid = 1; in_data = lane0(32'hAAAA0000);
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_a got=%b exp=1", in_ready); end
    in_data = lane0(32'hBBBB0000);
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_b got=%b exp=0", in_ready); end
    total++; if (out_data !== lane0(32'hAAAA0000)) begin bad++; $display("FAIL bp_hold_a got=%h exp=%h", out_data, lane0(32'hAAAA0000)); end
    in_data = lane0(32'hCCCC0000);
    step();
    total++; if (out_data !== lane0(32'hAAAA0000) || in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall got=%h/%b exp=A/0", out_data, in_ready); end
    in_valid = 0; out_ready = 1;
    step();
    total++; if (out_data !== lane0(32'hBBBB0000)) begin bad++; $display("FAIL bp_b got=%h exp=%h", out_data, lane0(32'hBBBB0000)); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
    step();
    total++; if (out_valid !== 1'b0 || out_data !== '0) begin bad++; $display("FAIL bp_drain got=%b/%h exp=0/0", out_valid, out_data); end
  endtask
  task automatic test_flush();
    out_ready = 0; in_valid = 1;
    in_data = rand_data(); step();
    in_data = rand_data(); step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_full got=%b exp=0", in_ready); end
    flush = 1; in_data = lane0(32'h55);
    step();
    flush = 0; in_valid = 0; out_ready = 1;
    total++; if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_clear got=%b/%h/%b exp=0/0/1", out_valid, out_data, in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_data === lane0(32'h55) || out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak cyc%0d got=%b/%h exp=0/0", i, out_valid, out_data); end
    end
  endtask
  task automatic test_reset_mid();
    out_ready = 0; in_valid = 1; in_data = rand_data();
    step();
    reset = 1; flush = 1; out_ready = 1; in_data = rand_data();
    step();
    reset = 0; flush = 0; in_valid = 0;
    total++; if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid got=%b/%h/%b exp=0/0/1", out_valid, out_data, in_ready); end
`ifdef PIPE_STAGE_STATS_EN
    total++; if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d/%0d exp=0/0", stall_cnt, bubble_cnt); end
`endif
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 40) == 0);
      in_data = rand_data();
      step();
      total++; if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_valid cyc%0d got=%b exp=%b", i, out_valid, q.size() > 0); end
      total++; if (out_data !== m_data()) begin bad++; $display("FAIL rnd_data cyc%0d got=%h exp=%h", i, out_data, m_data()); end
      total++; if (in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rnd_ready cyc%0d got=%b exp=%b", i, in_ready, q.size() < 2); end
`ifdef PIPE_STAGE_STATS_EN
      total++; if (stall_cnt !== 32'(m_stall) || bubble_cnt !== 32'(m_bubble)) begin bad++; $display("FAIL rnd_cnt cyc%0d got=%0d/%0d exp=%0d/%0d", i, stall_cnt, bubble_cnt, m_stall, m_bubble); end
`endif
    end
    flush = 0;
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
